fir_coef_loader: RTL and testbench

Run-time coefficient reload controller for the adjustable-tap FIR chain. It accepts a coefficient stream over a valid/ready handshake and shifts the coefficients into the chain through the shared tap-write strobe. While it loads, it withholds input samples from the filter. After loading, it flushes the sample and accumulator pipeline with zeros, so no output mixes old and new coefficients. It sits between the sample source and the FIR input, alongside the coefficient port.

---
 rtl/fir_coef_loader_pkg.sv | 15 +
 rtl/fir_coef_loader.sv | 151 +++++++++++++++
 tb/tb_fir_coef_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_coef_loader_pkg.sv
// Shared types for the FIR coefficient reload controller.
package fir_coef_loader_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Two forwarding registers per tap plus the product and accumulator stages.
  function automatic int flush_len(input int ntaps);
    return 2 * ntaps + 2;
  endfunction

endpackage

// File: rtl/fir_coef_loader.sv
// Run-time coefficient reload controller: streams taps into the FIR chain,
// blocks samples during the load and flushes the pipeline with zeros.
module fir_coef_loader
  import fir_coef_loader_pkg::*;
#(
  parameter int NTAPS     = 128,
  parameter int TW        = 16,
  parameter int IW        = 16,
  parameter int FLUSH_LEN = flush_len(NTAPS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  input  logic          i_coef_valid,
  output logic          o_coef_ready,
  input  logic [TW-1:0] i_coef,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  input  logic          i_ce,
  input  logic [IW-1:0] i_sample,
  output logic          o_ce,
  output logic [IW-1:0] o_sample
);

  localparam int            CW         = $clog2(FLUSH_LEN + 1);
  localparam logic [CW-1:0] LAST_LOAD  = CW'(NTAPS - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(FLUSH_LEN - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          w_xfer;
  logic          r_busy, w_busy;
  logic          r_ready, w_ready;
  logic          r_done, w_done;
  logic          r_flush_end, w_flush_end;
  logic          r_tap_wr, w_tap_wr;
  logic [TW-1:0] r_tap, w_tap;
  logic          r_ce, w_ce;
  logic [IW-1:0] r_sample, w_sample;

  // r_ready is the registered LOAD decode, so it doubles as the accept qualifier.
  assign w_xfer = i_coef_valid && r_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (i_start) w_next = ST_LOAD;
        else         w_next = ST_RUN;
      end
      ST_LOAD: begin
        if (w_xfer && (r_cnt == LAST_LOAD)) w_next = ST_FLUSH;
        else                                w_next = ST_LOAD;
      end
      ST_FLUSH: begin
        if (r_cnt == LAST_FLUSH) w_next = ST_RUN;
        else                     w_next = ST_FLUSH;
      end
      default: w_next = ST_RUN;
    endcase
  end

  // Next values of the counter and all registered outputs.
  always_comb begin
    w_cnt       = r_cnt;
    w_ce        = 1'b0;
    w_sample    = {IW{1'b0}};
    w_tap_wr    = w_xfer;
    w_tap       = w_xfer ? i_coef : r_tap;
    w_ready     = (w_next == ST_LOAD);
    w_busy      = (w_next != ST_RUN) || (r_state == ST_FLUSH);
    w_flush_end = (r_state == ST_FLUSH) && (r_cnt == LAST_FLUSH);
    w_done      = r_flush_end;

    // The counter restarts on every state entry.
    if (w_next != r_state) begin
      w_cnt = {CW{1'b0}};
    end else if ((r_state == ST_LOAD) && w_xfer) begin
      w_cnt = r_cnt + CW'(1);
    end else if (r_state == ST_FLUSH) begin
      w_cnt = r_cnt + CW'(1);
    end else begin
      w_cnt = r_cnt;
    end

    case (r_state)
      ST_RUN: begin
        w_ce     = i_ce;
        w_sample = i_sample;
      end
      ST_LOAD: begin
        w_ce     = 1'b0;
        w_sample = {IW{1'b0}};
      end
      ST_FLUSH: begin
        w_ce     = 1'b1;
        w_sample = {IW{1'b0}};
      end
      default: begin
        w_ce     = 1'b0;
        w_sample = {IW{1'b0}};
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt       <= {CW{1'b0}};
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_flush_end <= 1'b0;
      r_tap_wr    <= 1'b0;
      r_tap       <= {TW{1'b0}};
      r_ce        <= 1'b0;
      r_sample    <= {IW{1'b0}};
    end else begin
      r_cnt       <= w_cnt;
      r_busy      <= w_busy;
      r_ready     <= w_ready;
      r_done      <= w_done;
      r_flush_end <= w_flush_end;
      r_tap_wr    <= w_tap_wr;
      r_tap       <= w_tap;
      r_ce        <= w_ce;
      r_sample    <= w_sample;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_coef_ready = r_ready;
  assign o_tap_wr     = r_tap_wr;
  assign o_tap        = r_tap;
  assign o_ce         = r_ce;
  assign o_sample     = r_sample;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed scoreboard bench for fir_coef_loader with a 4-tap chain.
module tb_fir_coef_loader;

  localparam int NTAPS     = 4;
  localparam int TW        = 16;
  localparam int IW        = 16;
  localparam int FLUSH_LEN = 2 * NTAPS + 2;

  logic          clk = 1'b0;
  logic          i_reset, i_start, i_coef_valid, i_ce;
  logic [TW-1:0] i_coef;
  logic [IW-1:0] i_sample;
  logic          o_busy, o_done, o_coef_ready, o_tap_wr, o_ce;
  logic [TW-1:0] o_tap;
  logic [IW-1:0] o_sample;

  always #5 clk = ~clk;

  fir_coef_loader #(.NTAPS(NTAPS), .TW(TW), .IW(IW), .FLUSH_LEN(FLUSH_LEN)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .i_coef_valid(i_coef_valid), .o_coef_ready(o_coef_ready), .i_coef(i_coef),
    .o_tap_wr(o_tap_wr), .o_tap(o_tap), .i_ce(i_ce), .i_sample(i_sample),
    .o_ce(o_ce), .o_sample(o_sample)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [TW-1:0] tapq[$];
  logic [IW:0]   sampq[$];
  int n_tapwr, n_done, n_zero, n_nz, first_zero, last_zero, first_tw, last_tw;
  int c0, done_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_tapwr = 0; n_done = 0; n_zero = 0; n_nz = 0;
    first_zero = -1; last_zero = -1; first_tw = -1; last_tw = -1;
  endtask

  // One clock; outputs observed 1 ns after the edge and scored against the tap queue.
  task automatic tick();
    logic [TW-1:0] exp_tap;
    @(posedge clk);
    #1;
    cyc++;
    if (o_tap_wr) begin
      chk("tap_expected", 32'(tapq.size() != 0), 32'd1);
      if (tapq.size() != 0) begin
        exp_tap = tapq.pop_front();
        chk("tap_value", 32'(o_tap), 32'(exp_tap));
      end
      n_tapwr++;
      if (first_tw < 0) first_tw = cyc;
      last_tw = cyc;
    end
    if (o_done) n_done++;
    if (o_ce && (o_sample == {IW{1'b0}})) begin
      n_zero++;
      if (first_zero < 0) first_zero = cyc;
      last_zero = cyc;
    end
    if (o_ce && (o_sample != {IW{1'b0}}) && !o_done) n_nz++;
  endtask

  task automatic send(input logic [TW-1:0] v);
    i_coef_valid = 1'b1;
    i_coef       = v;
    tapq.push_back(v);
    tick();
  endtask

  task automatic gap();
    i_coef_valid = 1'b0;
    i_coef       = 16'h5A5A;
    tick();
  endtask

  task automatic start();
    c0      = cyc;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    done_at = -1;
    for (int k = 0; k < bound && done_at < 0; k++) begin
      tick();
      if (o_done) done_at = cyc;
    end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_coef_valid = 1'b0; i_coef = 16'h0000;
    i_ce = 1'b0; i_sample = 16'h0000;
    clear_stats();

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ready", 32'(o_coef_ready), 32'd0);
    chk("rst_tap_wr", 32'(o_tap_wr), 32'd0);
    chk("rst_tap", 32'(o_tap), 32'd0);
    chk("rst_ce", 32'(o_ce), 32'd0);
    chk("rst_sample", 32'(o_sample), 32'd0);
    i_reset = 1'b0;

    // RUN forwarding with one cycle of latency
    for (int k = 0; k < 6; k++) begin
      logic [IW:0] exp_s;
      i_ce     = (k % 2 == 0);
      i_sample = 16'd5;
      sampq.push_back({i_ce, i_sample});
      tick();
      exp_s = sampq.pop_front();
      chk("run_ce", 32'(o_ce), 32'(exp_s[IW]));
      chk("run_sample", 32'(o_sample), 32'(exp_s[IW-1:0]));
    end
    chk("run_busy", 32'(o_busy), 32'd0);
    chk("run_ready", 32'(o_coef_ready), 32'd0);
    i_ce = 1'b0;

    // Full reload, valid held high
    clear_stats();
    start();
    chk("full_ready", 32'(o_coef_ready), 32'd1);
    chk("full_busy", 32'(o_busy), 32'd1);
    send(16'd4); send(16'd3); send(16'd2); send(16'd1);
    i_coef_valid = 1'b0;
    chk("full_ready_off", 32'(o_coef_ready), 32'd0);
    wait_done(60);
    chk("full_done_lat", 32'(done_at - c0), 32'd16);
    chk("full_tapwr_n", 32'(n_tapwr), 32'd4);
    chk("full_tapwr_first", 32'(first_tw - c0), 32'd2);
    chk("full_tapwr_last", 32'(last_tw - c0), 32'd5);
    chk("full_zero_n", 32'(n_zero), 32'(FLUSH_LEN));
    chk("full_zero_first", 32'(first_zero - c0), 32'd6);
    chk("full_zero_last", 32'(last_zero - c0), 32'd15);
    chk("full_busy_end", 32'(o_busy), 32'd0);
    chk("full_tap_hold", 32'(o_tap), 32'd1);
    tick();
    chk("full_done_pulse", 32'(o_done), 32'd0);

    // Backpressure gaps with sample blocking (i_ce=1, sample 7 throughout)
    i_ce = 1'b1; i_sample = 16'd7;
    tick();
    clear_stats();
    start();
    chk("blk_fwd_ce", 32'(o_ce), 32'd1);
    chk("blk_fwd_sample", 32'(o_sample), 32'd7);
    n_nz = 0;
    send(16'hA1B2); gap(); send(16'h0003); gap(); send(16'hFFFF); gap(); send(16'h8000);
    i_coef_valid = 1'b0;
    wait_done(60);
    chk("bp_tapwr_n", 32'(n_tapwr), 32'd4);
    chk("bp_flush_after_last", 32'(first_zero - last_tw), 32'd1);
    chk("bp_done_lat", 32'(done_at - c0), 32'd19);
    chk("blk_nonzero_ce", 32'(n_nz), 32'd0);
    chk("blk_resume_ce", 32'(o_ce), 32'd1);
    chk("blk_resume_sample", 32'(o_sample), 32'd7);
    i_ce = 1'b0; i_sample = 16'd0;

    // Redundant start in LOAD and in FLUSH
    tick();
    clear_stats();
    start();
    send(16'd9);
    i_start = 1'b1;
    send(16'd8);
    i_start = 1'b0;
    send(16'd7); send(16'd6);
    i_coef_valid = 1'b0;
    tick(); tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(60);
    chk("redund_done_lat", 32'(done_at - c0), 32'd16);
    for (int k = 0; k < 6; k++) tick();
    chk("redund_done_n", 32'(n_done), 32'd1);
    chk("redund_tapwr_n", 32'(n_tapwr), 32'd4);
    chk("redund_busy", 32'(o_busy), 32'd0);

    // Reset after two transfers, then a clean reload
    clear_stats();
    start();
    send(16'h0011); send(16'h0022);
    i_coef_valid = 1'b0;
    i_reset = 1'b1;
    tick();
    chk("mid_ready", 32'(o_coef_ready), 32'd0);
    chk("mid_busy", 32'(o_busy), 32'd0);
    chk("mid_tap_wr", 32'(o_tap_wr), 32'd0);
    i_reset = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("mid_no_done", 32'(n_done), 32'd0);
    chk("mid_no_ce", 32'(n_zero + n_nz), 32'd0);
    clear_stats();
    start();
    send(16'h1234); send(16'h5678); send(16'h9ABC); send(16'hDEF0);
    i_coef_valid = 1'b0;
    wait_done(60);
    chk("reload_tapwr_n", 32'(n_tapwr), 32'd4);
    chk("reload_done_lat", 32'(done_at - c0), 32'd16);
    chk("reload_zero_n", 32'(n_zero), 32'(FLUSH_LEN));
    chk("tapq_drained", 32'(tapq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
